// File: rtl/counter_pkg.sv
// Shared types and constants for the counter control block.
package counter_pkg;

  localparam int unsigned COUNT_W = 16;
  localparam logic [COUNT_W-1:0] COUNT_MAX = 16'd9999;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StPause,
    StClear,
    StLoad
  } ctrl_state_e;

  // Exact-match compare, so out-of-range values (>9999) never roll over.
  function automatic logic is_rollover(input logic down, input logic [COUNT_W-1:0] value);
    return down ? (value == '0) : (value == COUNT_MAX);
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for one asynchronous input plus a rising-edge detector.
module btn_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  always_comb begin
    sync1_d = async_i;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign level_o = sync2_q;
  // Combinational edge keeps input-to-FSM latency at two clocks.
  assign rise_o  = sync2_q & ~prev_q;

endmodule

// File: rtl/counter_ctrl.sv
// Button-driven control FSM for a 4-digit counter: tick prescaler, direction latch,
// load/clear requests and a rollover buzzer.
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned BUZZ_TICKS = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_start,
  input  logic               btn_stop,
  input  logic               btn_clear,
  input  logic               btn_load,
  input  logic               sw_updown,
  input  logic [COUNT_W-1:0] count,
  output logic               tick,
  output logic               state,
  output logic               updown,
  output logic               result_load,
  output logic               result_reset,
  output logic               buzzer,
  output logic               run_led
);

  localparam int unsigned PreW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BuzzW = $clog2(BUZZ_TICKS + 1);
  localparam logic [PreW-1:0]  PreMax   = PreW'(TICK_DIV - 1);
  localparam logic [BuzzW-1:0] BuzzLoad = BuzzW'(BUZZ_TICKS);

  logic start_ev, stop_ev, clear_ev, load_ev;
  logic sw_sync, sw_rise_unused;
  logic start_lvl_unused, stop_lvl_unused, clear_lvl_unused, load_lvl_unused;

  btn_sync u_sync_start (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .async_i(btn_start),
    .level_o(start_lvl_unused),
    .rise_o (start_ev)
  );

  btn_sync u_sync_stop (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .async_i(btn_stop),
    .level_o(stop_lvl_unused),
    .rise_o (stop_ev)
  );

  btn_sync u_sync_clear (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .async_i(btn_clear),
    .level_o(clear_lvl_unused),
    .rise_o (clear_ev)
  );

  btn_sync u_sync_load (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .async_i(btn_load),
    .level_o(load_lvl_unused),
    .rise_o (load_ev)
  );

  btn_sync u_sync_sw (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .async_i(sw_updown),
    .level_o(sw_sync),
    .rise_o (sw_rise_unused)
  );

  ctrl_state_e      state_q, state_d;
  logic [PreW-1:0]  presc_q, presc_d;
  logic [BuzzW-1:0] buzz_q, buzz_d;
  logic             updown_q, updown_d;
  logic             rst_hold_q, rst_hold_d;
  logic             counting, tick_int, rollover;

  assign counting = (state_q == StRun) || (state_q == StLoad);
  assign tick_int = counting && (presc_q == PreMax);
  assign rollover = tick_int && (state_q == StRun) && is_rollover(updown_q, count);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StPause: begin
        if (load_ev) begin
          state_d = StLoad;
        end else if (start_ev) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (stop_ev) state_d = StPause;
      end
      StLoad: begin
        if (tick_int) state_d = StPause;
      end
      StClear: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (clear_ev) state_d = StClear;
  end

  always_comb begin
    presc_d = '0;
    // Held at zero outside RUN/LOAD, so every entry starts a full tick period.
    if (counting) begin
      presc_d = (presc_q == PreMax) ? '0 : presc_q + PreW'(1);
    end

    buzz_d = buzz_q;
    if (clear_ev) begin
      buzz_d = '0;
    end else if (rollover) begin
      buzz_d = BuzzLoad;
    end else if (tick_int && (buzz_q != '0)) begin
      buzz_d = buzz_q - BuzzW'(1);
    end

    updown_d   = ((state_q == StIdle) || (state_q == StPause)) ? sw_sync : updown_q;
    rst_hold_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      presc_q    <= '0;
      buzz_q     <= '0;
      updown_q   <= 1'b0;
      rst_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      buzz_q     <= buzz_d;
      updown_q   <= updown_d;
      rst_hold_q <= rst_hold_d;
    end
  end

  assign tick         = tick_int;
  assign state        = ~counting;
  assign updown       = updown_q;
  assign result_load  = (state_q == StLoad);
  // Clear request also covers reset and the first cycle after it.
  assign result_reset = (state_q == StClear) || rst_hold_q;
  assign buzzer       = (buzz_q != '0);
  assign run_led      = (state_q == StRun);

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed self-checking bench for counter_ctrl with TICK_DIV=4, BUZZ_TICKS=2.
module tb_counter_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_start = 1'b0;
  logic        btn_stop = 1'b0;
  logic        btn_clear = 1'b0;
  logic        btn_load = 1'b0;
  logic        sw_updown = 1'b0;
  logic [15:0] count = 16'd0;
  logic        tick, state, updown, result_load, result_reset, buzzer, run_led;

  int total = 0;
  int bad = 0;

  counter_ctrl #(
    .TICK_DIV  (4),
    .BUZZ_TICKS(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_start   (btn_start),
    .btn_stop    (btn_stop),
    .btn_clear   (btn_clear),
    .btn_load    (btn_load),
    .sw_updown   (sw_updown),
    .count       (count),
    .tick        (tick),
    .state       (state),
    .updown      (updown),
    .result_load (result_load),
    .result_reset(result_reset),
    .buzzer      (buzzer),
    .run_led     (run_led)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1);
  end

  // Advance to 1ns after the next rising edge; all driving and sampling happens there.
  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  // One-cycle pulse: 0 start, 1 stop, 2 clear, 3 load.
  task automatic pulse(input int which);
    case (which)
      0: btn_start = 1'b1;
      1: btn_stop  = 1'b1;
      2: btn_clear = 1'b1;
      default: btn_load = 1'b1;
    endcase
    clk1();
    btn_start = 1'b0;
    btn_stop  = 1'b0;
    btn_clear = 1'b0;
    btn_load  = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) clk1();
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL rst_tick: got %b want 0", tick); end
    total++; if (state !== 1'b1) begin bad++; $display("FAIL rst_state: got %b want 1", state); end
    total++; if (updown !== 1'b0) begin bad++; $display("FAIL rst_updown: got %b want 0", updown); end
    total++;
    if (result_load !== 1'b0) begin bad++; $display("FAIL rst_load: got %b want 0", result_load); end
    total++;
    if (result_reset !== 1'b1) begin bad++; $display("FAIL rst_rr: got %b want 1", result_reset); end
    total++; if (buzzer !== 1'b0) begin bad++; $display("FAIL rst_buzz: got %b want 0", buzzer); end
    total++; if (run_led !== 1'b0) begin bad++; $display("FAIL rst_led: got %b want 0", run_led); end
    rst_n = 1'b1;
    #1;
    total++;
    if (result_reset !== 1'b1) begin bad++; $display("FAIL rr_hold: got %b want 1", result_reset); end
    clk1();
    total++;
    if (result_reset !== 1'b0) begin bad++; $display("FAIL rr_drop: got %b want 0", result_reset); end
    total++; if (state !== 1'b1) begin bad++; $display("FAIL idle_state: got %b want 1", state); end
  endtask

  task automatic test_run_ticks();
    pulse(0);
    clk1();
    total++; if (run_led !== 1'b0) begin bad++; $display("FAIL start_lat: got %b want 0", run_led); end
    clk1();
    total++; if (state !== 1'b0) begin bad++; $display("FAIL run_state: got %b want 0", state); end
    total++; if (run_led !== 1'b1) begin bad++; $display("FAIL run_led: got %b want 1", run_led); end
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL tick_e0: got %b want 0", tick); end
    for (int i = 1; i <= 12; i++) begin
      clk1();
      total++;
      if (tick !== ((i % 4) == 3)) begin
        bad++;
        $display("FAIL tick_cyc%0d: got %b want %b", i, tick, ((i % 4) == 3));
      end
    end
  endtask

  task automatic test_rollover();
    count = 16'd9999;
    for (int i = 13; i <= 28; i++) begin
      clk1();
      total++;
      if (buzzer !== (i >= 16 && i <= 23)) begin
        bad++;
        $display("FAIL buzz_cyc%0d: got %b want %b", i, buzzer, (i >= 16 && i <= 23));
      end
      if (i == 16) count = 16'd10000;
    end
  endtask

  task automatic test_updown();
    sw_updown = 1'b1;
    repeat (4) clk1();
    total++; if (updown !== 1'b0) begin bad++; $display("FAIL ud_frozen: got %b want 0", updown); end
    pulse(1);
    clk1();
    clk1();
    total++; if (state !== 1'b1) begin bad++; $display("FAIL pause_state: got %b want 1", state); end
    total++; if (run_led !== 1'b0) begin bad++; $display("FAIL pause_led: got %b want 0", run_led); end
    clk1();
    total++; if (updown !== 1'b1) begin bad++; $display("FAIL ud_follow: got %b want 1", updown); end
    sw_updown = 1'b0;
    clk1();
    total++; if (updown !== 1'b1) begin bad++; $display("FAIL ud_lat1: got %b want 1", updown); end
    clk1();
    total++; if (updown !== 1'b1) begin bad++; $display("FAIL ud_lat2: got %b want 1", updown); end
    clk1();
    total++; if (updown !== 1'b0) begin bad++; $display("FAIL ud_lat3: got %b want 0", updown); end
  endtask

  task automatic test_load();
    sw_updown = 1'b1;
    count     = 16'd0;
    repeat (3) clk1();
    total++; if (updown !== 1'b1) begin bad++; $display("FAIL ld_ud: got %b want 1", updown); end
    pulse(3);
    clk1();
    clk1();
    total++;
    if (result_load !== 1'b1) begin bad++; $display("FAIL ld_on: got %b want 1", result_load); end
    total++; if (state !== 1'b0) begin bad++; $display("FAIL ld_state: got %b want 0", state); end
    for (int i = 1; i <= 3; i++) begin
      clk1();
      total++;
      if (result_load !== 1'b1 || tick !== (i == 3)) begin
        bad++;
        $display("FAIL ld_cyc%0d: got load=%b tick=%b want load=1 tick=%b",
                 i, result_load, tick, (i == 3));
      end
    end
    clk1();
    total++;
    if (result_load !== 1'b0) begin bad++; $display("FAIL ld_off: got %b want 0", result_load); end
    total++; if (state !== 1'b1) begin bad++; $display("FAIL ld_pause: got %b want 1", state); end
    total++; if (buzzer !== 1'b0) begin bad++; $display("FAIL ld_buzz: got %b want 0", buzzer); end
  endtask

  task automatic test_clear_priority();
    pulse(0);
    clk1();
    clk1();
    total++; if (run_led !== 1'b1) begin bad++; $display("FAIL cp_run: got %b want 1", run_led); end
    repeat (4) clk1();
    total++; if (buzzer !== 1'b1) begin bad++; $display("FAIL cp_buzz: got %b want 1", buzzer); end
    count     = 16'd5;
    btn_clear = 1'b1;
    btn_start = 1'b1;
    clk1();
    btn_clear = 1'b0;
    btn_start = 1'b0;
    clk1();
    total++;
    if (buzzer !== 1'b1 || run_led !== 1'b1) begin
      bad++;
      $display("FAIL cp_pre: got buzz=%b led=%b want buzz=1 led=1", buzzer, run_led);
    end
    clk1();
    total++;
    if (result_reset !== 1'b1) begin bad++; $display("FAIL cp_rr: got %b want 1", result_reset); end
    total++; if (buzzer !== 1'b0) begin bad++; $display("FAIL cp_buzz0: got %b want 0", buzzer); end
    total++; if (run_led !== 1'b0) begin bad++; $display("FAIL cp_led: got %b want 0", run_led); end
    clk1();
    total++;
    if (result_reset !== 1'b0) begin bad++; $display("FAIL cp_rr1: got %b want 0", result_reset); end
    total++; if (state !== 1'b1) begin bad++; $display("FAIL cp_idle: got %b want 1", state); end
    repeat (4) clk1();
    total++;
    if (run_led !== 1'b0 || tick !== 1'b0) begin
      bad++;
      $display("FAIL cp_stay: got led=%b tick=%b want led=0 tick=0", run_led, tick);
    end
  endtask

  task automatic test_reset_mid_load();
    pulse(3);
    clk1();
    clk1();
    total++;
    if (result_load !== 1'b1) begin bad++; $display("FAIL ml_on: got %b want 1", result_load); end
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (result_load !== 1'b0) begin bad++; $display("FAIL ml_load: got %b want 0", result_load); end
    total++;
    if (result_reset !== 1'b1) begin bad++; $display("FAIL ml_rr: got %b want 1", result_reset); end
    total++; if (state !== 1'b1) begin bad++; $display("FAIL ml_state: got %b want 1", state); end
    total++; if (updown !== 1'b0) begin bad++; $display("FAIL ml_ud: got %b want 0", updown); end
    total++;
    if (tick !== 1'b0 || buzzer !== 1'b0 || run_led !== 1'b0) begin
      bad++;
      $display("FAIL ml_outs: got tick=%b buzz=%b led=%b want 0 0 0", tick, buzzer, run_led);
    end
    clk1();
    clk1();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      clk1();
      total++;
      if (result_load !== 1'b0 || tick !== 1'b0) begin
        bad++;
        $display("FAIL ml_post%0d: got load=%b tick=%b want 0 0", i, result_load, tick);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_ticks();
    test_rollover();
    test_updown();
    test_load();
    test_clear_priority();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
